// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg : state, decode-class and datapath mux encodings for the CPU
// Revision: 1.0
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CLS_RTYPE = 4'd0,
    CLS_ITYPE = 4'd1,
    CLS_SHIFT = 4'd2,
    CLS_LUI   = 4'd3,
    CLS_BCOND = 4'd4,
    CLS_LOAD  = 4'd5,
    CLS_STOR  = 4'd6,
    CLS_JAL   = 4'd7,
    CLS_JCOND = 4'd8,
    CLS_NOP   = 4'd9
  } op_class_e;

  localparam logic [3:0] OP_RTYPE  = 4'b0000;
  localparam logic [3:0] OP_SHIFT  = 4'b1000;
  localparam logic [3:0] OP_LUI    = 4'b1111;
  localparam logic [3:0] OP_BCOND  = 4'b1100;
  localparam logic [3:0] OP_MISC   = 4'b0100;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  localparam logic [1:0] PC_INC    = 2'd0;
  localparam logic [1:0] PC_JUMP   = 2'd1;
  localparam logic [1:0] PC_BRANCH = 2'd2;

  localparam logic [1:0] WSEL_ALU  = 2'd0;
  localparam logic [1:0] WSEL_MEM  = 2'd1;
  localparam logic [1:0] WSEL_LINK = 2'd2;

  function automatic op_class_e decode_class(input logic [7:0] opcode);
    op_class_e cls;
    case (opcode[7:4])
      OP_RTYPE: cls = CLS_RTYPE;
      OP_SHIFT: cls = CLS_SHIFT;
      OP_LUI:   cls = CLS_LUI;
      OP_BCOND: cls = CLS_BCOND;
      OP_MISC: begin
        case (opcode[3:0])
          EXT_LOAD:  cls = CLS_LOAD;
          EXT_STOR:  cls = CLS_STOR;
          EXT_JAL:   cls = CLS_JAL;
          EXT_JCOND: cls = CLS_JCOND;
          default:   cls = CLS_NOP;
        endcase
      end
      default:  cls = CLS_ITYPE;
    endcase
    return cls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_wait_timer : counts unanswered memory-request cycles against a limit
// Revision: 1.0
// ---------------------------------------------------------------------------
module mem_wait_timer #(
  parameter int TMR_W = 5
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             count_en_i,
  input  logic [TMR_W-1:0] limit_i,
  output logic             expired_o
);

  logic [TMR_W-1:0] cnt_q;

  always_ff @(posedge clock_i) begin
    if (reset_i || clear_i) begin
      cnt_q <= '0;
    end else if (count_en_i && (cnt_q != limit_i)) begin
      cnt_q <= cnt_q + TMR_W'(1);
    end
  end

  // High when one more unanswered cycle brings the count to the limit.
  assign expired_o = (cnt_q == (limit_i - TMR_W'(1)));

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_sequencer : multi-cycle fetch/decode/execute/memory control FSM
// Revision: 1.0
// ---------------------------------------------------------------------------
module cpu_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMR_W       = 5
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       run_i,
  input  logic [7:0] opcode_i,
  input  logic       cond_true_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       addr_sel_o,
  output logic       ir_load_o,
  output logic       pc_en_o,
  output logic [1:0] pc_src_o,
  output logic       rf_we_o,
  output logic [1:0] rf_wsel_o,
  output logic       alu_imm_o,
  output logic       flags_we_o,
  output logic       fault_o,
  output logic       busy_o
);

  state_e    state_q, state_d;
  logic      fault_q;
  op_class_e cls;
  state_e    retire_state;
  logic      tmr_clear, tmr_count, tmr_expired;

  assign tmr_clear = (state_q != ST_FETCH) && (state_q != ST_MEM);
  assign tmr_count = !tmr_clear && !mem_ready_i;

  mem_wait_timer #(.TMR_W(TMR_W)) u_timer (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .clear_i    (tmr_clear),
    .count_en_i (tmr_count),
    .limit_i    (TMR_W'(MEM_TIMEOUT)),
    .expired_o  (tmr_expired)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == ST_FAULT) fault_q <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    addr_sel_o = 1'b0;
    ir_load_o  = 1'b0;
    pc_en_o    = 1'b0;
    pc_src_o   = PC_INC;
    rf_we_o    = 1'b0;
    rf_wsel_o  = WSEL_ALU;
    alu_imm_o  = 1'b0;
    flags_we_o = 1'b0;
    cls        = decode_class(opcode_i);
    // run is only honoured when an instruction boundary is reached.
    retire_state = run_i ? ST_FETCH : ST_IDLE;

    case (state_q)
      ST_IDLE: begin
        if (run_i) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          ir_load_o = 1'b1;
          state_d   = ST_DECODE;
        end else if (tmr_expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        pc_en_o = 1'b1;
        state_d = retire_state;
        case (cls)
          CLS_RTYPE, CLS_ITYPE: begin
            rf_we_o    = 1'b1;
            flags_we_o = 1'b1;
            alu_imm_o  = (cls == CLS_ITYPE);
          end
          CLS_SHIFT, CLS_LUI: begin
            rf_we_o   = 1'b1;
            alu_imm_o = (cls == CLS_LUI) || opcode_i[0];
          end
          CLS_JAL: begin
            rf_we_o   = 1'b1;
            rf_wsel_o = WSEL_LINK;
            pc_src_o  = PC_JUMP;
          end
          CLS_JCOND: pc_src_o = cond_true_i ? PC_JUMP : PC_INC;
          CLS_BCOND: pc_src_o = cond_true_i ? PC_BRANCH : PC_INC;
          CLS_LOAD, CLS_STOR: begin
            pc_en_o = 1'b0;
            state_d = ST_MEM;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        mem_req_o  = 1'b1;
        addr_sel_o = 1'b1;
        mem_we_o   = (cls == CLS_STOR);
        if (mem_ready_i) begin
          pc_en_o = 1'b1;
          if (cls == CLS_LOAD) begin
            rf_we_o   = 1'b1;
            rf_wsel_o = WSEL_MEM;
          end
          state_d = retire_state;
        end else if (tmr_expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  assign fault_o = fault_q;
  assign busy_o  = (state_q != ST_IDLE) && (state_q != ST_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cpu_sequencer : scoreboard bench comparing per-cycle control outputs
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_cpu_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [7:0] opcode = 8'h00;
  logic       cond_true = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, addr_sel, ir_load, pc_en, rf_we, alu_imm, flags_we, fault, busy;
  logic [1:0] pc_src, rf_wsel;

  always #5 clock = ~clock;

  cpu_sequencer #(.MEM_TIMEOUT(16), .TMR_W(5)) dut (
    .clock_i     (clock),
    .reset_i     (reset),
    .run_i       (run),
    .opcode_i    (opcode),
    .cond_true_i (cond_true),
    .mem_ready_i (mem_ready),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .addr_sel_o  (addr_sel),
    .ir_load_o   (ir_load),
    .pc_en_o     (pc_en),
    .pc_src_o    (pc_src),
    .rf_we_o     (rf_we),
    .rf_wsel_o   (rf_wsel),
    .alu_imm_o   (alu_imm),
    .flags_we_o  (flags_we),
    .fault_o     (fault),
    .busy_o      (busy)
  );

  // Expected-output bit positions in the packed observation vector.
  localparam logic [13:0] E0        = 14'h0000;
  localparam logic [13:0] B_REQ     = 14'h2000;
  localparam logic [13:0] B_WE      = 14'h1000;
  localparam logic [13:0] B_ASEL    = 14'h0800;
  localparam logic [13:0] B_IRL     = 14'h0400;
  localparam logic [13:0] B_PCEN    = 14'h0200;
  localparam logic [13:0] B_SRC_B   = 14'h0100;
  localparam logic [13:0] B_SRC_J   = 14'h0080;
  localparam logic [13:0] B_RFWE    = 14'h0040;
  localparam logic [13:0] B_WS_LINK = 14'h0020;
  localparam logic [13:0] B_WS_MEM  = 14'h0010;
  localparam logic [13:0] B_IMM     = 14'h0008;
  localparam logic [13:0] B_FWE     = 14'h0004;
  localparam logic [13:0] B_FAULT   = 14'h0002;
  localparam logic [13:0] B_BUSY    = 14'h0001;

  typedef struct packed {
    logic       rst;
    logic       run;
    logic       cond;
    logic       rdy;
    logic [7:0] op;
    logic       chk;
  } stim_t;

  stim_t       stim_q[$];
  logic [13:0] exp_q[$];
  string       tag_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [13:0] act, input logic [13:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (req,we,asel,irl,pcen,src[2],rfwe,wsel[2],imm,fwe,fault,busy)",
               tag, act, exp);
    end
  endtask

  task automatic push(input string tag, input logic rst, input logic r, input logic c,
                      input logic rdy, input logic [7:0] op, input logic chk,
                      input logic [13:0] exp);
    stim_t s;
    s = '{rst: rst, run: r, cond: c, rdy: rdy, op: op, chk: chk};
    stim_q.push_back(s);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  // Zero-wait fetch, decode, then the EXEC cycle with its expected strobes.
  task automatic instr(input string tag, input logic [7:0] op, input logic c,
                       input logic run_exec, input logic [13:0] exp_exec);
    push({tag, "_fetch"},  1'b0, 1'b1, c, 1'b1, op, 1'b1, B_REQ | B_IRL | B_BUSY);
    push({tag, "_decode"}, 1'b0, 1'b1, c, 1'b0, op, 1'b1, B_BUSY);
    push({tag, "_exec"},   1'b0, run_exec, c, 1'b0, op, 1'b1, exp_exec);
  endtask

  function automatic logic [13:0] observe();
    return {mem_req, mem_we, addr_sel, ir_load, pc_en, pc_src, rf_we, rf_wsel,
            alu_imm, flags_we, fault, busy};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    stim_t       s;
    logic [13:0] e;
    string       t;

    push("power_on",    1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, E0);
    push("reset_state", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, E0);
    push("idle_start",  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, E0);

    instr("rtype05", 8'h05, 1'b0, 1'b1, B_RFWE | B_FWE | B_PCEN | B_BUSY);
    push("fetch_wait", 1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 1'b1, B_REQ | B_BUSY);

    instr("load40", 8'h40, 1'b0, 1'b1, B_BUSY);
    for (int i = 0; i < 3; i++)
      push("load_mem_wait", 1'b0, 1'b1, 1'b0, 1'b0, 8'h40, 1'b1, B_REQ | B_ASEL | B_BUSY);
    push("load_mem_done", 1'b0, 1'b1, 1'b0, 1'b1, 8'h40, 1'b1,
         B_REQ | B_ASEL | B_RFWE | B_WS_MEM | B_PCEN | B_BUSY);

    instr("stor44", 8'h44, 1'b0, 1'b1, B_BUSY);
    push("stor_mem_done", 1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 1'b1,
         B_REQ | B_WE | B_ASEL | B_PCEN | B_BUSY);

    instr("bcondC0_t", 8'hC0, 1'b1, 1'b1, B_PCEN | B_SRC_B | B_BUSY);
    instr("bcondC3_f", 8'hC3, 1'b0, 1'b1, B_PCEN | B_BUSY);
    instr("jcond4C_f", 8'h4C, 1'b0, 1'b1, B_PCEN | B_BUSY);
    instr("jcond4C_t", 8'h4C, 1'b1, 1'b1, B_PCEN | B_SRC_J | B_BUSY);
    instr("jal48",     8'h48, 1'b0, 1'b1, B_RFWE | B_WS_LINK | B_SRC_J | B_PCEN | B_BUSY);
    instr("shift80",   8'h80, 1'b0, 1'b1, B_RFWE | B_PCEN | B_BUSY);
    instr("shift81",   8'h81, 1'b0, 1'b1, B_RFWE | B_IMM | B_PCEN | B_BUSY);
    instr("luiF2",     8'hF2, 1'b0, 1'b1, B_RFWE | B_IMM | B_PCEN | B_BUSY);
    instr("nop41",     8'h41, 1'b0, 1'b1, B_PCEN | B_BUSY);
    instr("itype51",   8'h51, 1'b0, 1'b0, B_RFWE | B_FWE | B_IMM | B_PCEN | B_BUSY);
    push("idle_after_stop", 1'b0, 1'b0, 1'b0, 1'b1, 8'h51, 1'b1, E0);
    push("idle_stays",      1'b0, 1'b0, 1'b0, 1'b0, 8'h51, 1'b1, E0);

    push("t1_idle", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, E0);
    instr("t1_load", 8'h40, 1'b0, 1'b1, B_BUSY);
    push("t1_mem_rst",   1'b1, 1'b1, 1'b0, 1'b0, 8'h40, 1'b1, B_REQ | B_ASEL | B_BUSY);
    push("t1_after_rst", 1'b0, 1'b0, 1'b0, 1'b1, 8'h40, 1'b1, E0);

    push("t5_idle", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, E0);
    for (int i = 0; i < 16; i++)
      push("t5_fetch_wait", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, B_REQ | B_BUSY);
    for (int i = 0; i < 4; i++)
      push("t5_fault", 1'b0, 1'b1, 1'b0, 1'(i % 2), 8'h00, 1'b1, B_FAULT);
    push("t5_fault_rst",   1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, B_FAULT);
    push("t5_after_rst",   1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, E0);

    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      @(posedge clock);
      #1;
      reset     = s.rst;
      run       = s.run;
      cond_true = s.cond;
      mem_ready = s.rdy;
      opcode    = s.op;
      @(negedge clock);
      if (s.chk) check(t, observe(), e);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
